// File: rtl/medidor_pwm_if.sv
// Bus bundle for medidor_pwm.
//   pwm_in      : asynchronous PWM input to be measured
//   leer        : read strobe, acknowledges dato_listo
//   ancho       : last captured high time (cycles)
//   periodo     : last captured rise-to-rise period (cycles)
//   dato_listo  : new capture pending
//   sobrecarga  : sticky, a capture overwrote an unread one
//   fuera_rango : last ancho outside the legal servo window
//   timeout     : sticky, PWM went quiet; cleared by next capture
// master = the side driving pwm_in/leer, slave = the measurer.
interface medidor_pwm_if;
  logic        pwm_in;
  logic        leer;
  logic [19:0] ancho;
  logic [19:0] periodo;
  logic        dato_listo;
  logic        sobrecarga;
  logic        fuera_rango;
  logic        timeout;

  modport master (output pwm_in, leer,
                  input  ancho, periodo, dato_listo, sobrecarga, fuera_rango, timeout);
  modport slave  (input  pwm_in, leer,
                  output ancho, periodo, dato_listo, sobrecarga, fuera_rango, timeout);
endinterface

// File: rtl/medidor_pwm.sv
// Servo-style PWM measurer: captures high time and rise-to-rise period
// of pwm_in in clk_in cycles.
//   clk_in : system clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : medidor_pwm_if.slave (pwm_in, leer in; results out)
// Optional feature: define MEDIDOR_RANGO_EN to compute fuera_rango
// against [ANCHO_MIN, ANCHO_MAX]; otherwise fuera_rango is tied to 0.
module medidor_pwm #(
  parameter logic [19:0] LIMITE_TO = 20'd1000000,
  parameter logic [19:0] ANCHO_MIN = 20'd25000,
  parameter logic [19:0] ANCHO_MAX = 20'd50000
) (
  input  logic          clk_in,
  input  logic          rst_n,
  medidor_pwm_if.slave  bus
);

  typedef enum logic [1:0] {ESPERA, ALTO, BAJO} estado_t;

  // Elaboration-time sanity check of the legal window.
  if (ANCHO_MIN > ANCHO_MAX) begin : g_rango_invalido
    $error("medidor_pwm: ANCHO_MIN > ANCHO_MAX");
  end

  estado_t     estado_q, estado_d;
  logic [2:0]  sinc_q, sinc_d;      // [1:0] synchronizer, [2] edge history
  logic [19:0] cnt_alto_q, cnt_alto_d;
  logic [19:0] cnt_total_q, cnt_total_d;
  logic [19:0] cnt_inact_q, cnt_inact_d; // cycles since last edge
  logic [19:0] ancho_q, ancho_d;
  logic [19:0] periodo_q, periodo_d;
  logic        dato_listo_q, dato_listo_d;
  logic        sobrecarga_q, sobrecarga_d;
  logic        fuera_rango_q, fuera_rango_d;
  logic        timeout_q, timeout_d;

  logic sube, baja, tout, fuera;

  function automatic logic [19:0] sat_inc(input logic [19:0] x);
    return (x == '1) ? x : x + 20'd1;
  endfunction

  assign sube = sinc_q[1] & ~sinc_q[2];
  assign baja = ~sinc_q[1] & sinc_q[2];
  // Fires on the cycle in which the idle count would reach LIMITE_TO.
  assign tout = (cnt_inact_q >= LIMITE_TO - 20'd1);

`ifdef MEDIDOR_RANGO_EN
  assign fuera = (cnt_alto_q < ANCHO_MIN) || (cnt_alto_q > ANCHO_MAX);
`else
  assign fuera = 1'b0;
`endif

  always_comb begin
    estado_d      = estado_q;
    sinc_d        = {sinc_q[1:0], bus.pwm_in};
    cnt_alto_d    = cnt_alto_q;
    cnt_total_d   = cnt_total_q;
    cnt_inact_d   = (sube || baja) ? 20'd0 : sat_inc(cnt_inact_q);
    ancho_d       = ancho_q;
    periodo_d     = periodo_q;
    dato_listo_d  = dato_listo_q;
    sobrecarga_d  = sobrecarga_q;
    fuera_rango_d = fuera_rango_q;
    timeout_d     = timeout_q;

    if (bus.leer) dato_listo_d = 1'b0;

    unique case (estado_q)
      ESPERA: begin
        // First rise only arms the counters; timeout stays until a capture.
        if (sube) begin
          estado_d    = ALTO;
          cnt_alto_d  = 20'd1;
          cnt_total_d = 20'd1;
        end
      end
      ALTO: begin
        if (baja) begin
          estado_d    = BAJO;
          cnt_total_d = sat_inc(cnt_total_q);
        end else if (tout) begin
          estado_d  = ESPERA;
          timeout_d = 1'b1;
        end else begin
          cnt_alto_d  = sat_inc(cnt_alto_q);
          cnt_total_d = sat_inc(cnt_total_q);
        end
      end
      BAJO: begin
        if (sube) begin
          estado_d      = ALTO;
          ancho_d       = cnt_alto_q;
          periodo_d     = cnt_total_q;
          dato_listo_d  = 1'b1;  // capture beats a simultaneous leer
          sobrecarga_d  = sobrecarga_q | (dato_listo_q & ~bus.leer);
          fuera_rango_d = fuera;
          timeout_d     = 1'b0;
          cnt_alto_d    = 20'd1;
          cnt_total_d   = 20'd1;
        end else if (tout) begin
          estado_d  = ESPERA;
          timeout_d = 1'b1;
        end else begin
          cnt_total_d = sat_inc(cnt_total_q);
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= ESPERA;
      sinc_q        <= '0;
      cnt_alto_q    <= '0;
      cnt_total_q   <= '0;
      cnt_inact_q   <= '0;
      ancho_q       <= '0;
      periodo_q     <= '0;
      dato_listo_q  <= 1'b0;
      sobrecarga_q  <= 1'b0;
      fuera_rango_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      sinc_q        <= sinc_d;
      cnt_alto_q    <= cnt_alto_d;
      cnt_total_q   <= cnt_total_d;
      cnt_inact_q   <= cnt_inact_d;
      ancho_q       <= ancho_d;
      periodo_q     <= periodo_d;
      dato_listo_q  <= dato_listo_d;
      sobrecarga_q  <= sobrecarga_d;
      fuera_rango_q <= fuera_rango_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.ancho       = ancho_q;
  assign bus.periodo     = periodo_q;
  assign bus.dato_listo  = dato_listo_q;
  assign bus.sobrecarga  = sobrecarga_q;
  assign bus.fuera_rango = fuera_rango_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_medidor_pwm.sv
// Bench for medidor_pwm with scaled parameters (window 250..500 cycles,
// timeout 2000 cycles) so every scenario fits in a short run.
module tb_medidor_pwm;
  localparam logic [19:0] LIMITE = 20'd2000;
`ifdef MEDIDOR_RANGO_EN
  localparam bit RANGO = 1'b1;
`else
  localparam bit RANGO = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n;
  medidor_pwm_if bus();

  medidor_pwm #(.LIMITE_TO(LIMITE), .ANCHO_MIN(20'd250), .ANCHO_MAX(20'd500))
    dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus));

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    bit          fuera;
  } vec_t;

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ancho"},   bus.ancho, 0);
    chk({nm, "_periodo"}, bus.periodo, 0);
    chk({nm, "_dato"},    bus.dato_listo, 0);
    chk({nm, "_sobre"},   bus.sobrecarga, 0);
    chk({nm, "_fuera"},   bus.fuera_rango, 0);
    chk({nm, "_tout"},    bus.timeout, 0);
  endtask

  vec_t vt[7];
  int   spent;

  initial begin
    vt[0] = '{375, 625, 1'b0};
    vt[1] = '{250, 750, 1'b0};  // lower bound is legal
    vt[2] = '{500, 500, 1'b0};  // upper bound is legal
    vt[3] = '{249, 751, 1'b1};
    vt[4] = '{501, 499, 1'b1};
    vt[5] = '{200, 300, 1'b1};
    vt[6] = '{100, 900, 1'b1};

    rst_n = 1'b0; bus.pwm_in = 1'b0; bus.leer = 1'b0;
    steps(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    steps(5);

    // Table: each frame is captured at the following rise (3 cycles of
    // sync/edge latency), then acknowledged with a one-cycle leer.
    bus.pwm_in = 1'b1;
    spent = 0;
    for (int i = 0; i < 7; i++) begin
      steps(vt[i].hi - spent);
      bus.pwm_in = 1'b0;
      steps(vt[i].lo);
      bus.pwm_in = 1'b1;
      steps(3);
      chk($sformatf("v%0d_ancho", i),   bus.ancho, vt[i].hi);
      chk($sformatf("v%0d_periodo", i), bus.periodo, vt[i].hi + vt[i].lo);
      chk($sformatf("v%0d_fuera", i),   bus.fuera_rango, vt[i].fuera & RANGO);
      chk($sformatf("v%0d_dato", i),    bus.dato_listo, 1);
      chk($sformatf("v%0d_sobre", i),   bus.sobrecarga, 0);
      bus.leer = 1'b1;
      step();
      bus.leer = 1'b0;
      chk($sformatf("v%0d_dato_leido", i), bus.dato_listo, 0);
      spent = 4;
    end

    // Overrun: two captures without leer.
    steps(300 - 4); bus.pwm_in = 1'b0; steps(700); bus.pwm_in = 1'b1; steps(3);
    chk("ovr_dato1", bus.dato_listo, 1);
    chk("ovr_sobre1", bus.sobrecarga, 0);
    steps(400 - 3); bus.pwm_in = 1'b0; steps(600); bus.pwm_in = 1'b1; steps(3);
    chk("ovr_sobre2", bus.sobrecarga, 1);
    chk("ovr_ancho", bus.ancho, 400);
    chk("ovr_periodo", bus.periodo, 1000);

    // Timeout: line quiet well past LIMITE.
    steps(100); bus.pwm_in = 1'b0; steps(2100);
    chk("to_flag", bus.timeout, 1);
    chk("to_ancho", bus.ancho, 400);
    chk("to_periodo", bus.periodo, 1000);
    bus.pwm_in = 1'b1; steps(3);
    chk("to_tras_subida", bus.timeout, 1);  // re-arm does not clear it
    steps(300 - 3); bus.pwm_in = 1'b0; steps(700); bus.pwm_in = 1'b1; steps(3);
    chk("to_limpio", bus.timeout, 0);
    chk("to_ancho2", bus.ancho, 300);
    chk("to_periodo2", bus.periodo, 1000);
    chk("to_sobre_sticky", bus.sobrecarga, 1);

    // Reset mid-high: outputs drop without waiting for a clock edge.
    steps(50);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    bus.pwm_in = 1'b0;
    steps(3);
    rst_n = 1'b1;
    steps(10);
    bus.pwm_in = 1'b1; steps(3);
    chk("rst_1a_subida", bus.dato_listo, 0);
    steps(375 - 3); bus.pwm_in = 1'b0; steps(625); bus.pwm_in = 1'b1; steps(3);
    chk("rst_2a_dato", bus.dato_listo, 1);
    chk("rst_2a_ancho", bus.ancho, 375);
    chk("rst_2a_periodo", bus.periodo, 1000);

    // leer in the exact capture cycle: capture wins, no overrun.
    steps(375 - 3); bus.pwm_in = 1'b0; steps(625);
    bus.pwm_in = 1'b1; steps(2);
    bus.leer = 1'b1; step(); bus.leer = 1'b0;
    chk("simul_dato", bus.dato_listo, 1);
    chk("simul_sobre", bus.sobrecarga, 0);

    // Random-phase edges, nominal 500 high / 1000 period.
    steps(200); bus.pwm_in = 1'b0; steps(300);
    #($urandom_range(1, 8));
    bus.pwm_in = 1'b1;
    #(4995 + $urandom_range(0, 10));
    bus.pwm_in = 1'b0;
    #(4995 + $urandom_range(0, 10));
    bus.pwm_in = 1'b1;
    steps(5);
    chk_rng("fase_ancho", bus.ancho, 499, 501);
    chk_rng("fase_periodo", bus.periodo, 998, 1002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/medidor_pwm.md
MEDIDOR_PWM -- requirements
Module: medidor_pwm

Interface
REQ-001 Parameter LIMITE_TO, default 20'd1000000, cycles without a pwm edge before timeout (40 ms at 25 MHz).
REQ-002 Parameter ANCHO_MIN, default 20'd25000, minimum legal high time in cycles (1 ms).
REQ-003 Parameter ANCHO_MAX, default 20'd50000, maximum legal high time in cycles (2 ms).
REQ-004 clk_in  input  1  single system clock, 25 MHz nominal, all logic on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pwm_in  input  1  asynchronous servo-style PWM input (nominal 50 Hz frame).
REQ-007 leer  input  1  read strobe; clears dato_listo.
REQ-008 ancho  output  20  last captured high time in clk_in cycles.
REQ-009 periodo  output  20  last captured rising-to-rising period in clk_in cycles.
REQ-010 dato_listo  output  1  new capture available, held until read.
REQ-011 sobrecarga  output  1  sticky: capture occurred while dato_listo was still set.
REQ-012 fuera_rango  output  1  last captured ancho outside [ANCHO_MIN, ANCHO_MAX].
REQ-013 timeout  output  1  sticky: no edge for LIMITE_TO cycles; cleared by next capture.

Function
REQ-014 pwm_in SHALL pass a 2-flop synchronizer; edges SHALL be detected on the synchronized signal with a third register; detected edge appears 3 cycles after the pwm_in transition.
REQ-015 FSM states SHALL be ESPERA (wait first rise), ALTO (count high), BAJO (count low).
REQ-016 ESPERA -> ALTO on rising edge, counters cnt_alto=1, cnt_total=1; no capture.
REQ-017 ALTO -> BAJO on falling edge; cnt_alto frozen; cnt_total keeps incrementing.
REQ-018 BAJO -> ALTO on rising edge; same cycle SHALL load ancho=cnt_alto, periodo=cnt_total, set dato_listo, restart counters at 1.
REQ-019 For a stable pwm_in high for exactly N cycles and period P cycles, capture SHALL report ancho=N, periodo=P.
REQ-020 Rising edge while in ALTO is impossible; glitch shorter than one cycle after sync SHALL be ignored by design of the synchronizer.
REQ-021 In ALTO or BAJO, when cycles since last edge reach LIMITE_TO, FSM SHALL go to ESPERA, set timeout, leave ancho/periodo unchanged; counters SHALL saturate, never wrap.
REQ-022 timeout SHALL clear on the next capture (REQ-018), not on the ESPERA->ALTO transition.
REQ-023 leer with dato_listo=1 SHALL clear dato_listo next cycle; leer with dato_listo=0 has no effect.
REQ-024 Capture with dato_listo=1 and leer=0 SHALL set sobrecarga and overwrite ancho/periodo; sobrecarga clears only on reset.
REQ-025 Capture and leer in the same cycle: capture wins, dato_listo stays 1, sobrecarga not set.
REQ-026 All outputs SHALL be registered; fuera_rango SHALL update in the capture cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force FSM=ESPERA, synchronizer flops=0, counters=0, ancho=0, periodo=0, dato_listo=0, sobrecarga=0, fuera_rango=0, timeout=0.
REQ-028 Reset mid-pulse SHALL discard the measurement; first capture after release requires two rising edges.
REQ-029 Reset release SHALL be synchronous-deasserted externally; block makes no assumption beyond asynchronous assertion.

Configuration
REQ-030 Macro MEDIDOR_RANGO_EN defined: fuera_rango computed per REQ-026 (ancho<ANCHO_MIN or ancho>ANCHO_MAX).
REQ-031 Macro MEDIDOR_RANGO_EN undefined: range comparators absent, fuera_rango tied to 0, ANCHO_MIN/ANCHO_MAX unused.

Verification
REQ-032 Reset, then pwm 37500 high / 462500 low, 3 frames -> first capture on 2nd rise: ancho=37500, periodo=500000, dato_listo=1, fuera_rango=0.
REQ-033 Frames without leer -> second capture sets sobrecarga=1; leer in exact capture cycle (separate run) -> dato_listo=1, sobrecarga=0.
REQ-034 pwm high 20000 cycles (0.8 ms), MEDIDOR_RANGO_EN defined -> fuera_rango=1; undefined -> fuera_rango=0.
REQ-035 pwm held low 1000000 cycles after a capture -> timeout=1, FSM ESPERA, ancho/periodo unchanged; two following frames -> timeout=0 at new capture.
REQ-036 rst_n pulsed low mid-high-phase -> all outputs 0 asynchronously; next valid capture only after two rising edges.
REQ-037 pwm_in toggled asynchronously to clk_in (random phase) -> ancho within +/-1 cycle of nominal 50000.
